// File: rtl/core_hazard_pkg.sv
// core_hazard_pkg: hazard-path types shared by the stall controller, forwarding unit and MUL/DIV unit
package core_hazard_pkg;
  typedef enum logic {RUN, MD_WAIT} hz_state_e;
  localparam int MD_TIMEOUT_DEF = 64;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags a load in Execute whose destination feeds the instruction in Decode
module load_use_detect (
  input  logic       load_e,
  input  logic [4:0] rd_e,
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  output logic       hazard
);
  assign hazard = load_e && rd_e != 5'd0 && (rd_e == rs1_d || rd_e == rs2_d);
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: stall/flush sequencer for load-use, branch, memory wait and MUL/DIV hazards
module pipeline_stall_ctrl
  import core_hazard_pkg::*;
#(
  parameter int MD_TIMEOUT = MD_TIMEOUT_DEF,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       RS1_D,
  input  logic [4:0]       RS2_D,
  input  logic [4:0]       RD_E,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  input  logic             MulDivE,
  input  logic             md_done,
  input  logic             MemReqM,
  input  logic             DMemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             FlushW,
  output logic             md_start,
  output logic             md_err,
  output logic [CNT_W-1:0] StallCount
);
  localparam int TW = MD_TIMEOUT > 1 ? $clog2(MD_TIMEOUT) : 1;
  hz_state_e         state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              lu, mem_wait, in_md, md_to, md_rel, md_hold, md_go, br, lu_go;
  load_use_detect u_lu (
    .load_e (ResultSrcE0),
    .rd_e   (RD_E),
    .rs1_d  (RS1_D),
    .rs2_d  (RS2_D),
    .hazard (lu)
  );
  // Decode priority: memory wait overrides everything, then MUL/DIV, branch, load-use
  always_comb begin
    mem_wait   = MemReqM && !DMemReadyM;
    in_md      = state_q == MD_WAIT;
    md_to      = in_md && !md_done && timer_q == TW'(MD_TIMEOUT - 1);
    md_rel     = in_md && (md_done || md_to);
    md_hold    = in_md && !md_rel;
    md_go      = !in_md && MulDivE;
    br         = !in_md && !MulDivE && PCSrcE;
    lu_go      = !in_md && !MulDivE && !PCSrcE && lu;
    StallF     = !rst && (mem_wait || md_go || md_hold || lu_go);
    StallD     = StallF;
    StallE     = !rst && (mem_wait || md_go || md_hold);
    StallM     = !rst && mem_wait;
    FlushD     = !rst && !mem_wait && br;
    FlushE     = !rst && !mem_wait && (br || lu_go);
    FlushM     = !rst && !mem_wait && (md_go || md_hold);
    FlushW     = !rst && mem_wait;
    md_start   = !rst && !mem_wait && md_go;
    state_d    = mem_wait ? state_q : md_go ? MD_WAIT : md_rel ? RUN : state_q;
    timer_d    = mem_wait ? timer_q : md_go ? '0 : md_hold ? timer_q + 1'b1 : timer_q;
    err_d      = err_q || (!mem_wait && md_to);
    cnt_d      = (StallF && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    md_err     = err_q;
    StallCount = cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      timer_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Stall/flush sequencer for the 5-stage RISC-V core, sitting beside the forwarding unit in the hazard path. It resolves the hazards forwarding cannot cover: load-use, taken branch/jump, data-memory wait, and multi-cycle MUL/DIV execution. For MUL/DIV it owns the start handshake to the iterative unit, holds the front of the pipe until completion, and watchdogs the unit. It also keeps a stall-cycle performance counter.

## Interface
- MD_TIMEOUT, 64: max cycles in MD_WAIT before forced release.
- CNT_W, 32: width of StallCount.

- clk  in  1  core clock.
- rst  in  1  reset, synchronous, active-high.
- RS1_D, RS2_D  in  5 each  source registers of instruction in Decode.
- RD_E  in  5  destination of instruction in Execute.
- ResultSrcE0  in  1  instruction in Execute is a load.
- PCSrcE  in  1  taken branch/jump resolved in Execute.
- MulDivE  in  1  instruction in Execute is a multi-cycle MUL/DIV.
- md_done  in  1  1-cycle completion pulse from the MUL/DIV unit.
- MemReqM  in  1  Memory stage issues a data-memory access.
- DMemReadyM  in  1  data memory accepts/completes the access this cycle.
- StallF, StallD, StallE, StallM  out  1 each  hold the respective pipeline register.
- FlushD, FlushE, FlushM, FlushW  out  1 each  load a bubble into the respective register.
- md_start  out  1  start pulse to the MUL/DIV unit.
- md_err  out  1  sticky: watchdog expired.
- StallCount  out  CNT_W  cycles with StallF=1 since reset, saturating.

## Operation
- States: RUN, MD_WAIT. Reset -> RUN; all outputs 0, timer 0, StallCount 0, md_err 0.
- Priority, highest first: memory wait, MUL/DIV, taken branch, load-use.
- Memory wait (any state): MemReqM & !DMemReadyM -> StallF/D/E/M=1, FlushW=1, all other flushes 0, md_start=0. State, timer and md_err are frozen.
- RUN, MulDivE=1: md_start=1 for this cycle only; StallF/D/E=1, FlushM=1; next state MD_WAIT, timer cleared.
- MD_WAIT, md_done=0: StallF/D/E=1, FlushM=1, md_start=0, timer+1.
- MD_WAIT, md_done=1: no stalls or flushes; Execute advances with the result; next state RUN.
- MD_WAIT, timer==MD_TIMEOUT-1 and md_done=0: md_err set and held until rst. Behave as md_done=1 that cycle and return to RUN.
- RUN, PCSrcE=1: FlushD=1, FlushE=1, no stalls.
- RUN, load-use: ResultSrcE0 & RD_E!=0 & (RD_E==RS1_D | RD_E==RS2_D) -> StallF=1, StallD=1, FlushE=1 for exactly one cycle.
- RD_E==0 never causes a load-use stall.
- A stall and a flush are never both asserted on the same pipeline register.
- MulDivE, PCSrcE and ResultSrcE0 are mutually exclusive by decode. If more than one is asserted, the priority list applies.
- StallCount increments on every cycle with StallF=1 and saturates at all-ones.

## Timing
- All Stall*/Flush*/md_start outputs are Mealy: combinational from state and current inputs, same cycle.
- md_start is high only on the RUN->MD_WAIT cycle. It is never re-asserted for the same instruction.
- MUL/DIV with md_done N cycles after md_start: StallF=1 for N cycles; Execute advances on the md_done cycle. Minimum N=1.
- md_done seen in RUN is ignored.
- If a memory wait occurs in the md_done cycle, md_done is not latched; the MUL/DIV unit holds md_done until the wait clears.
- rst mid-MD_WAIT: RUN next cycle; md_start is not re-issued for the aborted op.
- Registered state: FSM, timer (clog2(MD_TIMEOUT) bits), md_err, StallCount.

## Structure
- Package core_hazard_pkg holds the state enum (RUN, MD_WAIT) and the default MD_TIMEOUT. Shared with the forwarding unit and the MUL/DIV unit.
- One sub-module, load_use_detect, holds the combinational comparator. Everything else stays in the top.

## Test plan
- Load x5 in E, RS1_D=5 -> one cycle StallF=StallD=FlushE=1, then clear. Same with RD_E=0 -> no stall.
- PCSrcE=1 with no other hazard -> FlushD=FlushE=1 for one cycle, StallF=0, StallCount unchanged.
- MulDivE=1, md_done 5 cycles after start -> md_start single pulse. StallF=1 for 5 cycles, then RUN. StallCount +5.
- md_done never arrives, MD_TIMEOUT=8 -> release after 8 stall cycles. md_err=1 stays set until rst.
- MemReqM=1, DMemReadyM=0 for 3 cycles during MD_WAIT -> StallF/D/E/M=1, FlushW=1 for 3 cycles; timer frozen. MUL/DIV completion still works afterwards.
- rst asserted in MD_WAIT -> next cycle all outputs 0, state RUN, StallCount 0.
